// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension unit: mode encodings,
// skid-buffer state type and a width-generic extend function.
package imm_ext_pkg;

    // Widest vector the extend function handles internally.
    localparam int unsigned EXT_MAX_W = 64;

    localparam logic [1:0] EXT_SIGN   = 2'b00;
    localparam logic [1:0] EXT_ZERO   = 2'b01;
    localparam logic [1:0] EXT_UPPER  = 2'b10;
    localparam logic [1:0] EXT_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        SB_EMPTY = 2'b00,
        SB_MAIN  = 2'b01,
        SB_FULL  = 2'b10
    } skid_state_t;

    // Extends the low in_w bits of imm to out_w bits according to mode.
    // Bits at and above out_w in the result are always zero; callers
    // truncate to their own output width.
    function automatic logic [EXT_MAX_W-1:0] extend(
        input logic [EXT_MAX_W-1:0] imm,
        input int unsigned          in_w,
        input int unsigned          out_w,
        input int unsigned          br_shift,
        input logic [1:0]           mode
    );
        logic [EXT_MAX_W-1:0] low_mask;
        logic [EXT_MAX_W-1:0] out_mask;
        logic [EXT_MAX_W-1:0] zx;
        logic [EXT_MAX_W-1:0] sx;
        logic [EXT_MAX_W-1:0] res;
        low_mask = (EXT_MAX_W'(1) << in_w) - EXT_MAX_W'(1);
        out_mask = (EXT_MAX_W'(1) << out_w) - EXT_MAX_W'(1);
        zx       = imm & low_mask;
        sx       = imm[6'(in_w - 1)] ? (zx | ~low_mask) : zx;
        case (mode)
            EXT_SIGN:  res = sx;
            EXT_ZERO:  res = zx;
            EXT_UPPER: res = zx << (out_w - in_w);
            default:   res = sx << br_shift;
        endcase
        return res & out_mask;
    endfunction

endpackage

// File: rtl/imm_ext_pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with registered in_ready.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data upstream;
// out_valid/out_ready/out_data downstream. out_data comes from the main
// entry; the skid entry only fills when main is held by backpressure.
module skid_buf
    import imm_ext_pkg::*;
#(
    parameter int unsigned DATA_W = 34
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    skid_state_t       state;
    skid_state_t       state_next;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] main_next;
    logic [DATA_W-1:0] skid_next;
    logic              accept_c;
    logic              emit_c;

    assign accept_c = in_valid && in_ready;
    assign emit_c   = out_valid && out_ready;

    // State, storage and handshake flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SB_EMPTY;
            out_data  <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_next;
            out_data  <= main_next;
            skid_q    <= skid_next;
            out_valid <= (state_next != SB_EMPTY);
            in_ready  <= (state_next != SB_FULL);
        end
    end

    // Next-state and entry routing. An offer while FULL is ignored because
    // in_ready is already low in that state.
    always_comb begin
        state_next = state;
        main_next  = out_data;
        skid_next  = skid_q;
        unique case (state)
            SB_EMPTY: begin
                if (accept_c) begin
                    main_next  = in_data;
                    state_next = SB_MAIN;
                end
            end
            SB_MAIN: begin
                if (emit_c && accept_c) begin
                    main_next = in_data;
                end else if (emit_c) begin
                    state_next = SB_EMPTY;
                end else if (accept_c) begin
                    skid_next  = in_data;
                    state_next = SB_FULL;
                end
            end
            SB_FULL: begin
                if (emit_c) begin
                    main_next  = skid_q;
                    state_next = SB_MAIN;
                end
            end
            default: state_next = SB_EMPTY;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension unit (sign / zero / upper / branch-offset).
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_imm/in_mode
// from decode; out_valid/out_ready/out_data/out_mode to the operand mux.
// The result is computed combinationally and only {mode, result} is stored.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W     = 16,
    parameter int unsigned OUT_W    = 32,
    parameter int unsigned BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode
);

    localparam int unsigned DATA_W = OUT_W + 2;

    // Reject parameter sets where the branch shift would lose bits.
    generate
        if ((IN_W == 0) || (OUT_W < IN_W + BR_SHIFT) || (OUT_W >= EXT_MAX_W)) begin : g_bad_params
            $error("imm_ext_pipe: need 0 < IN_W and IN_W + BR_SHIFT <= OUT_W < %0d", EXT_MAX_W);
        end
    endgenerate

    logic [OUT_W-1:0]  ext_c;
    logic [DATA_W-1:0] buf_in_c;
    logic [DATA_W-1:0] buf_out;

    assign ext_c    = OUT_W'(extend(EXT_MAX_W'(in_imm), IN_W, OUT_W, BR_SHIFT, in_mode));
    assign buf_in_c = {in_mode, ext_c};

    skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (buf_in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
    );

    assign out_data = buf_out[OUT_W-1:0];
    assign out_mode = buf_out[DATA_W-1 -: 2];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed steps plus a randomized
// phase, all scored against an arithmetic reference model and FIFO queue.
module tb_imm_ext_pipe;
    import imm_ext_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_mode;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [11:0] b_in_imm;
    logic [1:0]  b_in_mode;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [31:0] b_out_data;
    logic [1:0]  b_out_mode;

    int tests = 0;
    int fails = 0;
    logic [33:0] q[$];

    always #5 clk = ~clk;

    imm_ext_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
    );

    imm_ext_pipe #(.IN_W(12), .OUT_W(32), .BR_SHIFT(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_imm(b_in_imm), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_mode(b_out_mode)
    );

    // Reference: treat the immediate as a number, extend arithmetically,
    // then reduce modulo 2^out_w.
    function automatic longint ref_ext(input int in_w, input int out_w, input int sh,
                                       input longint imm, input int mode);
        longint sval;
        longint v;
        longint m;
        m    = longint'(1) << out_w;
        sval = (imm >= (longint'(1) << (in_w - 1))) ? imm - (longint'(1) << in_w) : imm;
        case (mode)
            0:       v = sval;
            1:       v = imm;
            2:       v = imm * (longint'(1) << (out_w - in_w));
            default: v = sval * (longint'(1) << sh);
        endcase
        return ((v % m) + m) % m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the main DUT with the FIFO model updated from the
    // handshakes seen just before the edge and checked just after it.
    task automatic tick();
        bit          acc;
        bit          em;
        bit          stall;
        logic [33:0] prev;
        acc   = (in_valid === 1'b1) && (in_ready === 1'b1);
        em    = (out_valid === 1'b1) && (out_ready === 1'b1);
        stall = (out_valid === 1'b1) && (out_ready === 1'b0);
        prev  = {out_mode, out_data};
        if (em) begin
            chk("emit_has_word", 64'(q.size() > 0), 64'(1));
            if (q.size() > 0) void'(q.pop_front());
        end
        if (acc)
            q.push_back({in_mode, 32'(ref_ext(16, 32, 2, longint'(in_imm), int'(in_mode)))});
        @(posedge clk);
        #1;
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) chk("head", 64'({out_mode, out_data}), 64'(q[0]));
        if (stall) chk("stable", 64'({out_mode, out_data}), 64'(prev));
    endtask

    task automatic send_one(input logic [15:0] imm, input logic [1:0] mode, input logic [31:0] exp);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_imm    = imm;
        in_mode   = mode;
        tick();
        in_valid = 1'b0;
        chk("dir_valid", 64'(out_valid), 64'(1));
        chk("dir_data", 64'(out_data), 64'(exp));
        chk("dir_mode", 64'(out_mode), 64'(mode));
        tick();
        chk("dir_drained", 64'(out_valid), 64'(0));
    endtask

    task automatic send_b(input logic [11:0] imm, input logic [1:0] mode, input logic [31:0] exp);
        b_in_valid = 1'b1;
        b_in_imm   = imm;
        b_in_mode  = mode;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        chk("b_valid", 64'(b_out_valid), 64'(1));
        chk("b_data", 64'(b_out_data), 64'(exp));
        chk("b_model", 64'(b_out_data), 64'(ref_ext(12, 32, 1, longint'(imm), int'(mode))));
        chk("b_mode", 64'(b_out_mode), 64'(mode));
        @(posedge clk);
        #1;
        chk("b_drained", 64'(b_out_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_imm      = '0;
        in_mode     = '0;
        out_ready   = 1'b0;
        b_in_valid  = 1'b0;
        b_in_imm    = '0;
        b_in_mode   = '0;
        b_out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_mode", 64'(out_mode), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        rst_n = 1'b1;
        tick();

        // One word per mode
        send_one(16'hF111, EXT_SIGN,   32'hFFFFF111);
        send_one(16'hF111, EXT_ZERO,   32'h0000F111);
        send_one(16'hF111, EXT_UPPER,  32'hF1110000);
        send_one(16'hF111, EXT_BRANCH, 32'hFFFFC444);

        // Boundary values
        send_one(16'h7FFF, EXT_SIGN,   32'h00007FFF);
        send_one(16'h8000, EXT_BRANCH, 32'hFFFE0000);
        send_one(16'h0000, EXT_UPPER,  32'h00000000);
        send_one(16'hFFFF, EXT_ZERO,   32'h0000FFFF);

        // Streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_imm   = 16'(i);
            in_mode  = EXT_SIGN;
            chk("stream_ready", 64'(in_ready), 64'(1));
            tick();
            chk("stream_data", 64'(out_data), 64'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_done", 64'(out_valid), 64'(0));

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = EXT_SIGN;
        in_imm    = 16'h0001;
        tick();
        in_imm = 16'h0002;
        tick();
        chk("bp_ready_low", 64'(in_ready), 64'(0));
        in_imm = 16'h0003;
        tick();
        chk("bp_hold1", 64'(out_data), 64'(1));
        tick();
        chk("bp_hold2", 64'(out_data), 64'(1));
        chk("bp_ready_still_low", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        tick();
        chk("bp_emit2", 64'(out_data), 64'(2));
        tick();
        chk("bp_emit3", 64'(out_data), 64'(3));
        in_valid = 1'b0;
        tick();
        chk("bp_done", 64'(out_valid), 64'(0));

        // Reset mid-operation with both entries full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = EXT_ZERO;
        in_imm    = 16'h1234;
        tick();
        in_imm = 16'h5678;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_data", 64'(out_data), 64'(0));
        chk("mid_rst_ready", 64'(in_ready), 64'(0));
        q.delete();
        #1;
        rst_n = 1'b1;
        tick();
        send_one(16'hFFFF, EXT_SIGN, 32'hFFFFFFFF);

        // Parameter variant
        send_b(12'h800, EXT_SIGN,   32'hFFFFF800);
        send_b(12'hABC, EXT_UPPER,  32'hABC00000);
        send_b(12'hFFF, EXT_BRANCH, 32'hFFFFFFFE);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && q.size() > 0; i++) tick();
        chk("drain_empty", 64'(q.size()), 64'(0));
        chk("drain_valid", 64'(out_valid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
